trace_dispatch_ctrl: RTL and testbench

- Sits between the SD trace-line decoder and the LRU cache controller.
- Buffers parsed trace lines (tag, index, load/store, instruction count) in a small FIFO.
- Dispatches buffered lines to the cache controller with a valid/ready handshake.
- Sequences a run from start to end-of-file drain, then raises a done level that tells the VGA stats page to freeze.

---
 rtl/trace_dispatch_ctrl.sv | 157 +++++++++++++++
 tb/tb_trace_dispatch_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/trace_dispatch_ctrl.sv
// Trace-line dispatch controller: buffers decoded trace lines in a FWFT FIFO and
// hands them to the cache controller. Optional feature macro: DISPATCH_THROTTLE_EN.
module trace_dispatch_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 17,
  parameter int IDX_W      = 11,
  parameter int INST_W     = 21,
  parameter int GAP_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic [IDX_W-1:0]              in_index,
  input  logic                          in_ls,
  input  logic [INST_W-1:0]             in_inst,
  input  logic                          end_file,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TAG_W-1:0]              out_tag,
  output logic [IDX_W-1:0]              out_index,
  output logic                          out_ls,
  output logic [INST_W-1:0]             out_inst,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   lines_in,
  output logic [31:0]                   lines_out,
  output logic [31:0]                   dropped,
  output logic [1:0]                    state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = TAG_W + IDX_W + 1 + INST_W;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [DW-1:0]   head_q;
  logic [DW-1:0]   in_data;
  logic            push, pop, drop, go, gap_idle;

  assign in_data = {in_tag, in_index, in_ls, in_inst};

`ifdef DISPATCH_THROTTLE_EN
  localparam int GW = $clog2(GAP_CYCLES + 2);
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk) begin
    if (rst || go)          gap_cnt <= '0;
    else if (pop)           gap_cnt <= GW'(GAP_CYCLES);
    else if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
  end

  assign gap_idle = (gap_cnt == '0);
`else
  assign gap_idle = 1'b1;
`endif

  // Handshake: a line transfers on any edge where out_valid && out_ready; the
  // out_* fields stay stable while out_valid is high and out_ready is low.
  always_comb begin
    state_next = state;
    go         = 1'b0;
    out_valid  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: if (start) begin
        go         = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        out_valid = (count != '0) && gap_idle;
        pop       = out_valid && out_ready;
        if (in_valid) begin
          if ((count < FULL) || pop) push = 1'b1;
          else                       drop = 1'b1;
        end
        if (end_file) state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = (count != '0) && gap_idle;
        pop       = out_valid && out_ready;
        if ((count == '0) && gap_idle) state_next = DONE;
      end
      DONE: if (start) begin
        go         = 1'b1;
        state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_q    <= '0;
      overflow  <= 1'b0;
      lines_in  <= '0;
      lines_out <= '0;
      dropped   <= '0;
    end else if (go) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      lines_in  <= '0;
      lines_out <= '0;
      dropped   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      lines_in  <= lines_in + 32'(push);
      lines_out <= lines_out + 32'(pop);
      if (drop) begin
        overflow <= 1'b1;
        dropped  <= dropped + 32'd1;
      end
      // Head register tracks the next FWFT head and holds its value once empty.
      if (pop) begin
        if (count != CW'(1))   head_q <= mem[rd_ptr + AW'(1)];
        else if (push)         head_q <= in_data;
      end else if (push && (count == '0)) begin
        head_q <= in_data;
      end
    end
  end

  assign {out_tag, out_index, out_ls, out_inst} = head_q;
  assign fifo_count = count;
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_trace_dispatch_ctrl.sv
// Directed bench for trace_dispatch_ctrl: run sequencing, FIFO overflow,
// full-with-transfer, drain/done, reset abort, and optional dispatch throttling.
module tb_trace_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [16:0] in_tag = '0;
  logic [10:0] in_index = '0;
  logic        in_ls = 1'b0;
  logic [20:0] in_inst = '0;
  logic        end_file = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] out_tag;
  logic [10:0] out_index;
  logic        out_ls;
  logic [20:0] out_inst;
  logic        busy, done, overflow;
  logic [3:0]  fifo_count;
  logic [31:0] lines_in, lines_out, dropped;
  logic [1:0]  state_dbg;

  int passed = 0;
  int total  = 0;

  trace_dispatch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_tag(in_tag), .in_index(in_index), .in_ls(in_ls), .in_inst(in_inst),
    .end_file(end_file), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_index(out_index), .out_ls(out_ls), .out_inst(out_inst),
    .busy(busy), .done(done), .overflow(overflow), .fifo_count(fifo_count),
    .lines_in(lines_in), .lines_out(lines_out), .dropped(dropped),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    // Reset state
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);

    // IDLE ignores in_valid
    in_valid = 1'b1; in_tag = 17'h7; step(); in_valid = 1'b0;
    chk("idle_ignore_in", 32'(fifo_count), 32'd0);

    // Basic run: three lines streamed with out_ready held high
    start = 1'b1; step(); start = 1'b0;
    chk("run_state", 32'(state_dbg), 32'd1);
    chk("run_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_tag = 17'(i); in_index = 11'(i + 16); in_inst = 21'(i * 100);
      in_ls = i[0];
      step();
      chk($sformatf("basic_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("basic_tag_%0d", i), 32'(out_tag), 32'(i));
      chk($sformatf("basic_idx_%0d", i), 32'(out_index), 32'(i + 16));
      chk($sformatf("basic_inst_%0d", i), 32'(out_inst), 32'(i * 100));
      chk($sformatf("basic_ls_%0d", i), 32'(out_ls), 32'(i % 2));
    end
    in_valid = 1'b0; step();
    chk("basic_empty", 32'(fifo_count), 32'd0);
    chk("basic_lines_in", lines_in, 32'd3);
    chk("basic_lines_out", lines_out, 32'd3);
    end_file = 1'b1; step(); end_file = 1'b0;
    chk("basic_drain", 32'(state_dbg), 32'd2);
    step();
    chk("basic_done_state", 32'(state_dbg), 32'd3);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_done_valid", 32'(out_valid), 32'd0);

    // Overflow: nine lines into an eight-deep FIFO with the consumer stalled
    out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("restart_lines_in", lines_in, 32'd0);
    chk("restart_lines_out", lines_out, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1; in_tag = 17'(i); step();
    end
    in_valid = 1'b0;
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_dropped", dropped, 32'd1);
    chk("ovf_lines_in", lines_in, 32'd8);
    chk("ovf_head", 32'(out_tag), 32'd1);
    chk("ovf_stall_valid", 32'(out_valid), 32'd1);

    // Full FIFO with push and transfer in the same cycle
    out_ready = 1'b1; in_valid = 1'b1; in_tag = 17'hA; step(); in_valid = 1'b0;
    chk("full_xfer_count", 32'(fifo_count), 32'd8);
    chk("full_xfer_dropped", dropped, 32'd1);
    for (int i = 2; i <= 9; i++) begin
      chk($sformatf("order_tag_%0d", i), 32'(out_tag), (i == 9) ? 32'hA : 32'(i));
      step();
    end
    chk("order_empty", 32'(fifo_count), 32'd0);
    chk("order_lines_out", lines_out, 32'd9);
    chk("order_lines_in", lines_in, 32'd9);

    // end_file with empty FIFO; in_valid in DRAIN/DONE ignored
    end_file = 1'b1; step(); end_file = 1'b0;
    chk("empty_drain", 32'(state_dbg), 32'd2);
    in_valid = 1'b1; step();
    chk("empty_done", 32'(state_dbg), 32'd3);
    chk("drain_ignore_in", lines_in, 32'd9);
    end_file = 1'b1; step(); in_valid = 1'b0; end_file = 1'b0;
    chk("done_ignore_in", lines_in, 32'd9);
    chk("done_stays", 32'(state_dbg), 32'd3);
    start = 1'b1; step(); start = 1'b0;
    chk("done_restart_state", 32'(state_dbg), 32'd1);
    chk("done_restart_lines_out", lines_out, 32'd0);
    chk("done_restart_dropped", dropped, 32'd0);
    chk("done_restart_ovf", 32'(overflow), 32'd0);

    // Reset with five lines buffered
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_tag = 17'(8'h11 + i); in_index = 11'(i + 1); step();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(fifo_count), 32'd5);
    chk("pre_rst_head", 32'(out_tag), 32'h11);
    rst = 1'b1; step(); rst = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk("abort_state", 32'(state_dbg), 32'd0);
    chk("abort_lines_in", lines_in, 32'd0);
    chk("abort_tag", 32'(out_tag), 32'd0);
    chk("abort_index", 32'(out_index), 32'd0);

`ifdef DISPATCH_THROTTLE_EN
    begin
      int xfer_cyc[$];
      start = 1'b1; step(); start = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
        in_valid = (c < 3);
        in_tag = 17'(c + 1);
        if (out_valid && out_ready) xfer_cyc.push_back(c);
        step();
      end
      in_valid = 1'b0;
      chk("thr_xfers", 32'(xfer_cyc.size()), 32'd3);
      if (xfer_cyc.size() == 3) begin
        chk("thr_gap_1", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd5);
        chk("thr_gap_2", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd5);
      end
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
